// File: rtl/spu_rx_pkg.sv
// rtl/spu_rx_pkg.sv - shared types and helpers for the SPU RX payload packer
package spu_rx_pkg;

    typedef enum logic [0:0] {ST_HEADER, ST_PAYLOAD} state_t;

    localparam int HDR_BYTES_UDP = 42;
    localparam int MAX_BYTES     = 16;

    // Contiguous byte-enable mask covering bytes 0..ptr.
    function automatic logic [MAX_BYTES-1:0] keep_from_ptr(input logic [3:0] ptr);
        logic [MAX_BYTES:0] m;
        m = (17'd1 << ({1'b0, ptr} + 5'd1)) - 17'd1;
        return m[MAX_BYTES-1:0];
    endfunction

endpackage

// File: rtl/spu_byte_packer.sv
// rtl/spu_byte_packer.sv - packs accepted payload bytes into words behind a registered output stage
module spu_byte_packer
    import spu_rx_pkg::*;
#(
    parameter int DATA_BYTES = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    input  logic [7:0]              in_data,
    input  logic                    in_err,
    input  logic                    in_last,
    output logic                    in_ready,
    output logic [DATA_BYTES*8-1:0] m_tdata,
    output logic [DATA_BYTES-1:0]   m_tkeep,
    output logic                    m_tuser,
    output logic                    m_tlast,
    output logic                    m_tvalid,
    input  logic                    m_tready
);

    localparam int PW = $clog2(DATA_BYTES);

    logic [PW-1:0]           ptr_q, ptr_d;
    logic [DATA_BYTES*8-1:0] pack_q, pack_d;
    logic [DATA_BYTES*8-1:0] tdata_q, tdata_d;
    logic [DATA_BYTES-1:0]   tkeep_q, tkeep_d;
    logic                    tuser_q, tuser_d;
    logic                    tlast_q, tlast_d;
    logic                    tvalid_q, tvalid_d;

    logic [DATA_BYTES*8-1:0] merged;
    logic [DATA_BYTES*8-1:0] masked;
    logic [MAX_BYTES-1:0]    keep_full;

    always_comb begin
        ptr_d     = ptr_q;
        pack_d    = pack_q;
        tdata_d   = tdata_q;
        tkeep_d   = tkeep_q;
        tuser_d   = tuser_q;
        tlast_d   = tlast_q;
        tvalid_d  = tvalid_q;
        in_ready  = !tvalid_q || m_tready;
        keep_full = keep_from_ptr(4'(ptr_q));
        merged    = pack_q;
        merged[ptr_q*8 +: 8] = in_data;
        // Stale bytes from the previous word are zeroed above the keep boundary.
        for (int k = 0; k < DATA_BYTES; k++) begin
            masked[k*8 +: 8] = keep_full[k] ? merged[k*8 +: 8] : 8'h00;
        end
        if (tvalid_q && m_tready) begin
            tvalid_d = 1'b0;
        end
        if (in_valid && in_ready) begin
            pack_d = merged;
            if (ptr_q == PW'(DATA_BYTES-1) || in_last) begin
                tdata_d  = masked;
                tkeep_d  = keep_full[DATA_BYTES-1:0];
                tlast_d  = in_last;
                tuser_d  = in_err && in_last;
                tvalid_d = 1'b1;
                ptr_d    = '0;
            end else begin
                ptr_d = ptr_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q    <= '0;
            pack_q   <= '0;
            tdata_q  <= '0;
            tkeep_q  <= '0;
            tuser_q  <= 1'b0;
            tlast_q  <= 1'b0;
            tvalid_q <= 1'b0;
        end else begin
            ptr_q    <= ptr_d;
            pack_q   <= pack_d;
            tdata_q  <= tdata_d;
            tkeep_q  <= tkeep_d;
            tuser_q  <= tuser_d;
            tlast_q  <= tlast_d;
            tvalid_q <= tvalid_d;
        end
    end

    assign m_tdata  = tdata_q;
    assign m_tkeep  = tkeep_q;
    assign m_tuser  = tuser_q;
    assign m_tlast  = tlast_q;
    assign m_tvalid = tvalid_q;

endmodule

// File: rtl/spu_rx_payload_packer.sv
// rtl/spu_rx_payload_packer.sv - strips the Eth/IPv4/UDP header and packs the payload into words
module spu_rx_payload_packer
    import spu_rx_pkg::*;
#(
    parameter int DATA_BYTES  = 8,
    parameter int HDR_BYTES   = HDR_BYTES_UDP,
    parameter int COUNT_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [7:0]              s_axi4s_tdata,
    input  logic                    s_axi4s_tuser,
    input  logic                    s_axi4s_tlast,
    input  logic                    s_axi4s_tvalid,
    output logic                    s_axi4s_tready,
    output logic [DATA_BYTES*8-1:0] m_axi4s_tdata,
    output logic [DATA_BYTES-1:0]   m_axi4s_tkeep,
    output logic                    m_axi4s_tuser,
    output logic                    m_axi4s_tlast,
    output logic                    m_axi4s_tvalid,
    input  logic                    m_axi4s_tready,
    output logic [COUNT_WIDTH-1:0]  frame_count,
    output logic [COUNT_WIDTH-1:0]  drop_count
);

    state_t                 state_q, state_d;
    logic [7:0]             hdr_cnt_q, hdr_cnt_d;
    logic                   err_q, err_d;
    logic [COUNT_WIDTH-1:0] frame_cnt_q, frame_cnt_d;
    logic [COUNT_WIDTH-1:0] drop_cnt_q, drop_cnt_d;
    logic                   pk_ready;
    logic                   s_acc;

    assign s_axi4s_tready = reset && ((state_q == ST_HEADER) || pk_ready);
    assign s_acc          = s_axi4s_tvalid && s_axi4s_tready;

    always_comb begin
        state_d     = state_q;
        hdr_cnt_d   = hdr_cnt_q;
        err_d       = err_q;
        frame_cnt_d = frame_cnt_q;
        drop_cnt_d  = drop_cnt_q;
        if (m_axi4s_tvalid && m_axi4s_tready && m_axi4s_tlast) begin
            frame_cnt_d = frame_cnt_q + 1'b1;
        end
        if (s_acc) begin
            err_d = err_q || s_axi4s_tuser;
            if (state_q == ST_HEADER) begin
                hdr_cnt_d = hdr_cnt_q + 1'b1;
                if (s_axi4s_tlast) begin
                    drop_cnt_d = drop_cnt_q + 1'b1;
                    hdr_cnt_d  = '0;
                    err_d      = 1'b0;
                end else if (hdr_cnt_q == 8'(HDR_BYTES-1)) begin
                    state_d = ST_PAYLOAD;
                end
            end else if (s_axi4s_tlast) begin
                state_d   = ST_HEADER;
                hdr_cnt_d = '0;
                err_d     = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_HEADER;
            hdr_cnt_q   <= '0;
            err_q       <= 1'b0;
            frame_cnt_q <= '0;
            drop_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            hdr_cnt_q   <= hdr_cnt_d;
            err_q       <= err_d;
            frame_cnt_q <= frame_cnt_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    assign frame_count = frame_cnt_q;
    assign drop_count  = drop_cnt_q;

    spu_byte_packer #(.DATA_BYTES(DATA_BYTES)) u_packer (
        .clk      (clk),
        .rst_n    (reset),
        .in_valid (s_axi4s_tvalid && (state_q == ST_PAYLOAD)),
        .in_data  (s_axi4s_tdata),
        .in_err   (err_q || s_axi4s_tuser),
        .in_last  (s_axi4s_tlast),
        .in_ready (pk_ready),
        .m_tdata  (m_axi4s_tdata),
        .m_tkeep  (m_axi4s_tkeep),
        .m_tuser  (m_axi4s_tuser),
        .m_tlast  (m_axi4s_tlast),
        .m_tvalid (m_axi4s_tvalid),
        .m_tready (m_axi4s_tready)
    );

endmodule

// File: tb/tb_spu_rx_payload_packer.sv
// tb/tb_spu_rx_payload_packer.sv - directed self-checking bench for spu_rx_payload_packer
module tb_spu_rx_payload_packer;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  s_tdata = '0;
    logic        s_tuser = 1'b0;
    logic        s_tlast = 1'b0;
    logic        s_tvalid = 1'b0;
    logic        s_tready;
    logic [63:0] m_tdata;
    logic [7:0]  m_tkeep;
    logic        m_tuser;
    logic        m_tlast;
    logic        m_tvalid;
    logic        m_tready = 1'b1;
    logic [31:0] frame_count;
    logic [31:0] drop_count;

    int n_vec  = 0;
    int n_miss = 0;
    int stalls = 0;

    logic [63:0] cq_data[$];
    logic [7:0]  cq_keep[$];
    logic        cq_last[$];
    logic        cq_user[$];

    always #5 clk = ~clk;

    spu_rx_payload_packer dut (
        .clk            (clk),
        .reset          (reset),
        .s_axi4s_tdata  (s_tdata),
        .s_axi4s_tuser  (s_tuser),
        .s_axi4s_tlast  (s_tlast),
        .s_axi4s_tvalid (s_tvalid),
        .s_axi4s_tready (s_tready),
        .m_axi4s_tdata  (m_tdata),
        .m_axi4s_tkeep  (m_tkeep),
        .m_axi4s_tuser  (m_tuser),
        .m_axi4s_tlast  (m_tlast),
        .m_axi4s_tvalid (m_tvalid),
        .m_axi4s_tready (m_tready),
        .frame_count    (frame_count),
        .drop_count     (drop_count)
    );

    always @(negedge clk) begin
        if (reset && m_tvalid && m_tready) begin
            cq_data.push_back(m_tdata);
            cq_keep.push_back(m_tkeep);
            cq_last.push_back(m_tlast);
            cq_user.push_back(m_tuser);
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] d, input logic u, input logic l);
        logic rdy;
        int   t = 0;
        s_tdata  = d;
        s_tuser  = u;
        s_tlast  = l;
        s_tvalid = 1'b1;
        forever begin
            @(negedge clk);
            rdy = s_tready;
            if (!rdy) stalls++;
            @(posedge clk);
            #1;
            if (rdy) break;
            t++;
            if (t > 1000) begin
                chk("send_timeout", 64'd0, 64'd1);
                break;
            end
        end
    endtask

    task automatic send_frame(input int len, input int err_idx, input bit trunc);
        for (int i = 0; i < len; i++) begin
            send_byte(8'(i), (i == err_idx), (i == len - 1) && !trunc);
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        s_tuser  = 1'b0;
    endtask

    task automatic clear_q();
        cq_data.delete();
        cq_keep.delete();
        cq_last.delete();
        cq_user.delete();
    endtask

    task automatic drain(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_frame(input int len, input bit err);
        int          np;
        int          nw;
        logic [63:0] ed;
        logic [7:0]  ek;
        np = len - 42;
        nw = (np > 0) ? (np + 7) / 8 : 0;
        chk("nwords", 64'(cq_data.size()), 64'(nw));
        for (int w = 0; w < nw && w < cq_data.size(); w++) begin
            ed = '0;
            ek = '0;
            for (int b = 0; b < 8; b++) begin
                if (w * 8 + b < np) begin
                    ed[b*8 +: 8] = 8'(42 + w * 8 + b);
                    ek[b] = 1'b1;
                end
            end
            chk("tdata", cq_data[w], ed);
            chk("tkeep", 64'(cq_keep[w]), 64'(ek));
            chk("tlast", 64'(cq_last[w]), 64'(w == nw - 1));
            chk("tuser", 64'(cq_user[w]), 64'(err && (w == nw - 1)));
        end
        clear_q();
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tvalid", 64'(m_tvalid), 64'd0);
        chk("rst_tdata", m_tdata, 64'd0);
        chk("rst_tkeep", 64'(m_tkeep), 64'd0);
        chk("rst_tready", 64'(s_tready), 64'd0);
        chk("rst_frames", 64'(frame_count), 64'd0);
        chk("rst_drops", 64'(drop_count), 64'd0);
        reset = 1'b1;
        @(posedge clk);
        #1;

        send_frame(50, -1, 1'b0);
        drain(4);
        chk("s1_word", cq_data.size() > 0 ? cq_data[0] : 64'd0, 64'h3130_2F2E_2D2C_2B2A);
        check_frame(50, 1'b0);
        chk("s1_frames", 64'(frame_count), 64'd1);

        send_frame(45, -1, 1'b0);
        chk("s2_latency", 64'(m_tvalid), 64'd1);
        drain(4);
        chk("s2_word", cq_data.size() > 0 ? cq_data[0] : 64'd0, 64'h0000_0000_002C_2B2A);
        check_frame(45, 1'b0);
        chk("s2_frames", 64'(frame_count), 64'd2);

        stalls = 0;
        send_frame(30, -1, 1'b0);
        send_frame(42, -1, 1'b0);
        drain(4);
        check_frame(42, 1'b0);
        chk("s3_drops", 64'(drop_count), 64'd2);
        chk("s3_stalls", 64'(stalls), 64'd0);
        chk("s3_frames", 64'(frame_count), 64'd2);

        stalls = 0;
        fork
            send_frame(100, -1, 1'b0);
            begin
                for (int c = 0; c < 500; c++) begin
                    @(negedge clk);
                    if (cq_data.size() >= 1) break;
                end
                @(posedge clk);
                #1;
                m_tready = 1'b0;
                repeat (20) @(posedge clk);
                #1;
                m_tready = 1'b1;
            end
        join
        drain(6);
        check_frame(100, 1'b0);
        chk("s4_stalled", 64'(stalls > 0), 64'd1);
        chk("s4_frames", 64'(frame_count), 64'd3);

        send_frame(60, 5, 1'b0);
        drain(4);
        check_frame(60, 1'b1);
        send_frame(50, -1, 1'b0);
        drain(4);
        check_frame(50, 1'b0);
        chk("s5_frames", 64'(frame_count), 64'd5);

        m_tready = 1'b0;
        send_frame(50, -1, 1'b1);
        chk("s6_pre_tvalid", 64'(m_tvalid), 64'd1);
        #2;
        reset = 1'b0;
        #1;
        chk("s6_tvalid", 64'(m_tvalid), 64'd0);
        chk("s6_tdata", m_tdata, 64'd0);
        chk("s6_tkeep", 64'(m_tkeep), 64'd0);
        chk("s6_tlast", 64'(m_tlast), 64'd0);
        chk("s6_tuser", 64'(m_tuser), 64'd0);
        chk("s6_tready", 64'(s_tready), 64'd0);
        chk("s6_frames", 64'(frame_count), 64'd0);
        chk("s6_drops", 64'(drop_count), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        reset    = 1'b1;
        m_tready = 1'b1;
        clear_q();
        send_frame(50, -1, 1'b0);
        drain(4);
        chk("s6_word", cq_data.size() > 0 ? cq_data[0] : 64'd0, 64'h3130_2F2E_2D2C_2B2A);
        check_frame(50, 1'b0);
        chk("s6_frames_after", 64'(frame_count), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
